// File: rtl/mem_access_unit.sv
// Load/store unit between a CPU request port and a word-wide memory with byte/half lane handling.
// Build option MISALIGN_EXC_EN: misaligned half/word accesses skip memory and raise rsp_exc.
module mem_access_unit (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_exc,
    output logic [31:0] addr,
    output logic [31:0] WPC,
    output logic [31:0] MemWrite,
    output logic        DMWr,
    input  logic [31:0] MemRead
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_MERGE, S_DONE} state_e;

    state_e          state_q, state_d;
    logic            we_q, we_d;
    logic [1:0]      size_q, size_d;
    logic            signed_q, signed_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [DW-1:0]   buf_q, buf_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_exc_q, rsp_exc_d;

    logic [AW-1:0]   eff_addr_c;
    logic [1:0]      lane_c;
    logic [7:0]      lane_b_c;
    logic [15:0]     lane_h_c;
    logic [DW-1:0]   load_c;
    logic [DW-1:0]   merged_c;
    logic            skip_c;
    logic            dmwr_c;
    logic [DW-1:0]   mem_wdata_c;

`ifdef MISALIGN_EXC_EN
    assign skip_c = ((size_q == 2'b01) && addr_q[0]) || (size_q[1] && (addr_q[1:0] != 2'b00));
`else
    assign skip_c = 1'b0;
`endif

    // Effective address: sub-word alignment is forced down to the access size.
    always_comb begin
        case (size_q)
            2'b00:   eff_addr_c = addr_q;
            2'b01:   eff_addr_c = {addr_q[AW-1:1], 1'b0};
            default: eff_addr_c = {addr_q[AW-1:2], 2'b00};
        endcase
        lane_c = eff_addr_c[1:0];
    end

    // Little-endian lane extraction and zero/sign extension for loads.
    always_comb begin
        case (lane_c)
            2'd0:    lane_b_c = MemRead[7:0];
            2'd1:    lane_b_c = MemRead[15:8];
            2'd2:    lane_b_c = MemRead[23:16];
            default: lane_b_c = MemRead[31:24];
        endcase
        lane_h_c = lane_c[1] ? MemRead[31:16] : MemRead[15:0];
        case (size_q)
            2'b00:   load_c = signed_q ? {{24{lane_b_c[7]}}, lane_b_c} : {24'b0, lane_b_c};
            2'b01:   load_c = signed_q ? {{16{lane_h_c[15]}}, lane_h_c} : {16'b0, lane_h_c};
            default: load_c = MemRead;
        endcase
    end

    // Read-modify-write merge: replace only the addressed lane(s) of the captured word.
    always_comb begin
        merged_c = buf_q;
        case (size_q)
            2'b00: begin
                case (lane_c)
                    2'd0:    merged_c[7:0]   = wdata_q[7:0];
                    2'd1:    merged_c[15:8]  = wdata_q[7:0];
                    2'd2:    merged_c[23:16] = wdata_q[7:0];
                    default: merged_c[31:24] = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (lane_c[1]) merged_c[31:16] = wdata_q[15:0];
                else           merged_c[15:0]  = wdata_q[15:0];
            end
            default: merged_c = wdata_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            pc_q        <= '0;
            buf_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_exc_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            pc_q        <= pc_d;
            buf_q       <= buf_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_exc_q   <= rsp_exc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        signed_d    = signed_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        pc_d        = pc_q;
        buf_d       = buf_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_exc_d   = rsp_exc_q;
        dmwr_c      = 1'b0;
        mem_wdata_c = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    pc_d     = req_pc;
                    state_d  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                rsp_rdata_d = '0;
                rsp_exc_d   = skip_c;
                state_d     = S_DONE;
                if (!skip_c) begin
                    if (we_q) begin
                        if (size_q[1]) begin
                            dmwr_c = 1'b1;
                        end else begin
                            buf_d   = MemRead;
                            state_d = S_MERGE;
                        end
                    end else begin
                        rsp_rdata_d = load_c;
                    end
                end
            end
            S_MERGE: begin
                dmwr_c      = 1'b1;
                mem_wdata_c = merged_c;
                state_d     = S_DONE;
            end
            S_DONE: begin
                rsp_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_exc   = rsp_exc_q;
    assign addr      = eff_addr_c;
    assign WPC       = pc_q;
    assign MemWrite  = mem_wdata_c;
    // Write strobe is gated by reset so a reset edge can never commit a write.
    assign DMWr      = dmwr_c & Reset_n;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 64-word behavioural memory.
module tb_mem_access_unit;

    logic        Clk;
    logic        Reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_exc;
    logic [31:0] addr;
    logic [31:0] WPC;
    logic [31:0] MemWrite;
    logic        DMWr;
    logic [31:0] MemRead;

    logic [31:0] mem [64];
    logic        tb_we;
    logic [5:0]  tb_waddr;
    logic [31:0] tb_wdata;
    int          wr_cnt;
    int          rv_cnt;

    int checks;
    int errors;

    logic        acc_ready;
    logic        acc_dmwr;
    logic [31:0] acc_addr;
    logic [31:0] acc_wpc;
    logic [31:0] acc_memwrite;

    mem_access_unit dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_exc(rsp_exc),
        .addr(addr), .WPC(WPC), .MemWrite(MemWrite), .DMWr(DMWr), .MemRead(MemRead)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign MemRead = mem[addr[7:2]];

    always @(posedge Clk) begin
        if (DMWr) begin
            mem[addr[7:2]] <= MemWrite;
            wr_cnt <= wr_cnt + 1;
        end else if (tb_we) begin
            mem[tb_waddr] <= tb_wdata;
        end
        if (rsp_valid) rv_cnt <= rv_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request; returns the response, edges from accept to rsp_valid, and writes seen.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc,
                          output logic [31:0] rd, output logic ex, output int lat, output int wd_n);
        int wc0;
        @(negedge Clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = a; req_wdata = wd; req_pc = pc;
        wc0 = wr_cnt;
        @(negedge Clk);
        req_valid = 1'b0;
        acc_ready = req_ready; acc_dmwr = DMWr; acc_addr = addr;
        acc_wpc = WPC; acc_memwrite = MemWrite;
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            @(negedge Clk);
            lat++;
        end
        rd = rsp_rdata;
        ex = rsp_exc;
        wd_n = wr_cnt - wc0;
    endtask

    logic [31:0] rd;
    logic        ex;
    int          lat;
    int          wdn;
    int          wc0;
    int          rv0;

    initial begin
        checks = 0; errors = 0; wr_cnt = 0; rv_cnt = 0;
        tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; req_pc = '0;
        acc_ready = 1'b0; acc_dmwr = 1'b0; acc_addr = '0; acc_wpc = '0; acc_memwrite = '0;
        Reset_n = 1'b0;

        // Preload memory while the unit is held in reset.
        for (int i = 0; i < 64; i++) begin
            @(negedge Clk);
            tb_we = 1'b1;
            tb_waddr = 6'(i);
            tb_wdata = (i == 8) ? 32'hAABBCCDD : (i == 16) ? 32'hCAFEF00D : 32'h0;
        end
        @(negedge Clk);
        tb_we = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_exc", 32'(rsp_exc), 32'h0);
        chk("rst_dmwr", 32'(DMWr), 32'h0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_wpc", WPC, 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        chk("rst_ready_after", 32'(req_ready), 32'h1);

        // sw 0x12345678 @0x10
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, 32'h100, rd, ex, lat, wdn);
        chk("sw_busy_ready", 32'(acc_ready), 32'h0);
        chk("sw_acc_dmwr", 32'(acc_dmwr), 32'h1);
        chk("sw_acc_addr", acc_addr, 32'h10);
        chk("sw_acc_wpc", acc_wpc, 32'h100);
        chk("sw_acc_wdata", acc_memwrite, 32'h12345678);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_writes", 32'(wdn), 32'd1);
        chk("sw_mem", mem[4], 32'h12345678);
        chk("sw_rdata", rd, 32'h0);

        // lw @0x10
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h104, rd, ex, lat, wdn);
        chk("lw_rdata", rd, 32'h12345678);
        chk("lw_lat", 32'(lat), 32'd2);
        chk("lw_writes", 32'(wdn), 32'd0);
        chk("lw_exc", 32'(ex), 32'h0);
        @(negedge Clk);
        chk("lw_valid_one_cycle", 32'(rsp_valid), 32'h0);

        // sb 0x11 @0x22 onto 0xAABBCCDD
        do_req(1'b1, 2'b00, 1'b0, 32'h22, 32'hFFFFFF11, 32'h108, rd, ex, lat, wdn);
        chk("sb_acc_dmwr", 32'(acc_dmwr), 32'h0);
        chk("sb_lat", 32'(lat), 32'd3);
        chk("sb_writes", 32'(wdn), 32'd1);
        chk("sb_mem", mem[8], 32'hAA11CCDD);

        do_req(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 32'h10C, rd, ex, lat, wdn);
        chk("lb_23", rd, 32'hFFFFFFAA);
        do_req(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 32'h110, rd, ex, lat, wdn);
        chk("lbu_23", rd, 32'h000000AA);
        do_req(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 32'h114, rd, ex, lat, wdn);
        chk("lb_21", rd, 32'hFFFFFFCC);
        do_req(1'b0, 2'b00, 1'b1, 32'h22, 32'h0, 32'h118, rd, ex, lat, wdn);
        chk("lb_22_pos", rd, 32'h00000011);

        // sh 0x8001 @0x32 onto zero
        do_req(1'b1, 2'b01, 1'b0, 32'h32, 32'h00008001, 32'h11C, rd, ex, lat, wdn);
        chk("sh_mem", mem[12], 32'h80010000);
        chk("sh_writes", 32'(wdn), 32'd1);
        do_req(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 32'h120, rd, ex, lat, wdn);
        chk("lh_32", rd, 32'hFFFF8001);
        do_req(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 32'h124, rd, ex, lat, wdn);
        chk("lhu_32", rd, 32'h00008001);
        do_req(1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 32'h128, rd, ex, lat, wdn);
        chk("lh_30", rd, 32'h00000000);

        // Reset asserted while the unit sits in MERGE
        @(negedge Clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h55; req_pc = 32'h12C;
        wc0 = wr_cnt; rv0 = rv_cnt;
        @(negedge Clk);
        req_valid = 1'b0;
        @(negedge Clk);
        chk("merge_dmwr_pre", 32'(DMWr), 32'h1);
        Reset_n = 1'b0;
        #1;
        chk("merge_dmwr_gated", 32'(DMWr), 32'h0);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        chk("merge_rst_ready", 32'(req_ready), 32'h1);
        repeat (3) @(negedge Clk);
        chk("merge_rst_writes", 32'(wr_cnt - wc0), 32'd0);
        chk("merge_rst_rspvalid", 32'(rv_cnt - rv0), 32'd0);
        chk("merge_rst_mem", mem[8], 32'hAA11CCDD);
        chk("merge_rst_wpc", WPC, 32'h0);

        // Misaligned accesses
        do_req(1'b0, 2'b10, 1'b0, 32'h41, 32'h0, 32'h130, rd, ex, lat, wdn);
`ifdef MISALIGN_EXC_EN
        chk("lw41_exc", 32'(ex), 32'h1);
        chk("lw41_rdata", rd, 32'h0);
        chk("lw41_lat", 32'(lat), 32'd2);
`else
        chk("lw41_exc", 32'(ex), 32'h0);
        chk("lw41_rdata", rd, 32'hCAFEF00D);
        chk("lw41_acc_addr", acc_addr, 32'h40);
`endif
        do_req(1'b1, 2'b01, 1'b0, 32'h33, 32'h0000BEEF, 32'h134, rd, ex, lat, wdn);
`ifdef MISALIGN_EXC_EN
        chk("sh33_exc", 32'(ex), 32'h1);
        chk("sh33_writes", 32'(wdn), 32'd0);
        chk("sh33_mem", mem[12], 32'h80010000);
`else
        chk("sh33_exc", 32'(ex), 32'h0);
        chk("sh33_writes", 32'(wdn), 32'd1);
        chk("sh33_mem", mem[12], 32'hBEEF0000);
`endif
        do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h138, rd, ex, lat, wdn);
        chk("lw40_after_exc", 32'(ex), 32'h0);
        chk("lw40_rdata", rd, 32'hCAFEF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
